// File: rtl/delay_pkg.sv
// Shared definitions for the delay timer: FSM state encoding and a
// constant-evaluable ceiling log2 used to size the prescaler.
package delay_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } st_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_timer_if.sv
// Control/status bundle between a protocol FSM (master) and the delay
// timer (slave).
// Handshake: there is no ready/valid pair. The timer samples start, stop,
// count_in and periodic on every rising clk edge; a start is a one-cycle
// request, and the outcome of that edge is reported one cycle later by the
// single-cycle pulses rdy (expiry), miss (start rejected) or err (count 0).
interface delay_timer_if #(
  parameter int WIDTH = 16
);
  import delay_pkg::*;

  logic             start;
  logic [WIDTH-1:0] count_in;
  logic             periodic;
  logic             stop;
  logic             rdy;
  logic             busy;
  logic             miss;
  logic             err;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] period_o;
  st_t              state;

  modport master (
    output start, count_in, periodic, stop,
    input  rdy, busy, miss, err, remaining, period_o, state
  );

  modport slave (
    input  start, count_in, periodic, stop,
    output rdy, busy, miss, err, remaining, period_o, state
  );

endinterface

// File: rtl/delay_prescaler.sv
// Clock prescaler: tick is high one clock out of every PRESCALE clocks.
// With PRESCALE=1 tick is constantly high.
module delay_prescaler
  import delay_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;

  // Count 0..PRESCALE-1, restarting from 0 on reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (PRESCALE == 1) ? 1'b1 : (r_cnt == LAST);

endmodule

// File: rtl/delay_timer.sv
// Programmable one-shot / periodic delay timer with optional retrigger,
// abort, prescaler and status pulses.
module delay_timer
  import delay_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int DEFAULT_COUNT = 10,
  parameter int PRESCALE      = 1,
  parameter int RETRIGGER     = 0
) (
  input  logic          clk,
  input  logic          rst,
  delay_timer_if.slave  bus
);

  st_t              r_state;
  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] r_period;
  logic             r_mode;
  logic             r_rdy;
  logic             r_miss;
  logic             r_err;

  logic w_tick;
  logic w_zero_cnt;
  logic w_expire;
  logic w_accept;
  logic w_reload;
  logic w_clr;

  assign w_zero_cnt = (bus.count_in == '0);
  assign w_expire   = (r_state == ST_RUN) && w_tick && (r_counter == WIDTH'(1));
  // A start is taken from IDLE, always when retriggerable, and on a one-shot
  // expiry edge so back-to-back intervals need no idle gap.
  assign w_accept   = !bus.stop && bus.start && !w_zero_cnt &&
                      ((r_state == ST_IDLE) || (RETRIGGER != 0) ||
                       (w_expire && !r_mode));
  assign w_reload   = !bus.stop && w_expire && r_mode;
  assign w_clr      = bus.stop || w_accept || w_reload;

  delay_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // Main FSM: load, count down, expire/reload, abort; pulses default low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_counter <= '0;
      r_period  <= WIDTH'(DEFAULT_COUNT);
      r_mode    <= 1'b0;
      r_rdy     <= 1'b0;
      r_miss    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rdy  <= 1'b0;
      r_miss <= 1'b0;
      r_err  <= 1'b0;
      if (bus.stop) begin
        r_state   <= ST_IDLE;
        r_counter <= '0;
      end else if (w_accept) begin
        r_rdy     <= w_expire;
        r_state   <= ST_RUN;
        r_counter <= bus.count_in;
        r_period  <= bus.count_in;
        r_mode    <= bus.periodic;
      end else begin
        if (bus.start && w_zero_cnt) begin
          r_err <= 1'b1;
        end else if (bus.start && (r_state == ST_RUN)) begin
          r_miss <= 1'b1;
        end
        if ((r_state == ST_RUN) && w_tick) begin
          if (w_expire) begin
            r_rdy <= 1'b1;
            if (r_mode) begin
              r_counter <= r_period;
            end else begin
              r_counter <= '0;
              r_state   <= ST_IDLE;
            end
          end else begin
            r_counter <= r_counter - 1'b1;
          end
        end
      end
    end
  end

  assign bus.rdy       = r_rdy;
  assign bus.miss      = r_miss;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.remaining = r_counter;
  assign bus.period_o  = r_period;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_delay_timer.sv
// Bench for delay_timer: three instances (plain, retriggerable, prescale 4)
// share one stimulus stream; each check targets the relevant instance.
module tb_delay_timer;
  import delay_pkg::*;

  localparam int W = 16;

  logic clk;
  logic rst;

  delay_timer_if #(.WIDTH(W)) if_a ();
  delay_timer_if #(.WIDTH(W)) if_b ();
  delay_timer_if #(.WIDTH(W)) if_c ();

  assign if_b.start    = if_a.start;
  assign if_b.count_in = if_a.count_in;
  assign if_b.periodic = if_a.periodic;
  assign if_b.stop     = if_a.stop;
  assign if_c.start    = if_a.start;
  assign if_c.count_in = if_a.count_in;
  assign if_c.periodic = if_a.periodic;
  assign if_c.stop     = if_a.stop;

  delay_timer #(.WIDTH(W), .DEFAULT_COUNT(10), .PRESCALE(1), .RETRIGGER(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  delay_timer #(.WIDTH(W), .DEFAULT_COUNT(10), .PRESCALE(1), .RETRIGGER(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  delay_timer #(.WIDTH(W), .DEFAULT_COUNT(10), .PRESCALE(4), .RETRIGGER(0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic s, input logic [W-1:0] c,
                       input logic p, input logic stp);
    rst           = r;
    if_a.start    = s;
    if_a.count_in = c;
    if_a.periodic = p;
    if_a.stop     = stp;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Advance past one active edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic         start;
    logic [W-1:0] cnt;
    logic         periodic;
    logic         stop;
    logic         e_rdy;
    logic         e_busy;
    logic         e_miss;
    logic         e_err;
    logic [W-1:0] e_rem;
    logic [W-1:0] e_per;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic r, input logic s, input int c, input logic p,
                      input logic stp, input logic e_rdy, input logic e_busy,
                      input logic e_miss, input logic e_err, input int e_rem,
                      input int e_per);
    vec_t v;
    v.rst = r; v.start = s; v.cnt = W'(c); v.periodic = p; v.stop = stp;
    v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_miss = e_miss; v.e_err = e_err;
    v.e_rem = W'(e_rem); v.e_per = W'(e_per);
    vq.push_back(v);
  endtask

  task automatic build_table();
    // reset state
    addv(1,0,0,0,0, 0,0,0,0, 0,10);
    // one-shot count 5
    addv(0,1,5,0,0, 0,1,0,0, 5,5);
    addv(0,0,0,0,0, 0,1,0,0, 4,5);
    addv(0,0,0,0,0, 0,1,0,0, 3,5);
    addv(0,0,0,0,0, 0,1,0,0, 2,5);
    addv(0,0,0,0,0, 0,1,0,0, 1,5);
    addv(0,0,0,0,0, 1,0,0,0, 0,5);
    addv(0,0,0,0,0, 0,0,0,0, 0,5);
    // periodic count 3, ten cycles, then stop
    addv(0,1,3,1,0, 0,1,0,0, 3,3);
    for (int i = 1; i <= 10; i++)
      addv(0,0,0,0,0, (i % 3 == 0), 1, 0, 0, (i % 3 == 0) ? 3 : 3 - (i % 3), 3);
    addv(0,0,0,0,1, 0,0,0,0, 0,3);
    addv(0,0,0,0,0, 0,0,0,0, 0,3);
    addv(0,0,0,0,0, 0,0,0,0, 0,3);
    // stop while idle does nothing
    addv(0,0,0,0,1, 0,0,0,0, 0,3);
    // count 0 from idle
    addv(0,1,0,0,0, 0,0,0,1, 0,3);
    addv(0,0,0,0,0, 0,0,0,0, 0,3);
    // count 0 while running: err, timer unaffected
    addv(0,1,4,0,0, 0,1,0,0, 4,4);
    addv(0,1,0,0,0, 0,1,0,1, 3,4);
    addv(0,0,0,0,0, 0,1,0,0, 2,4);
    addv(0,0,0,0,0, 0,1,0,0, 1,4);
    addv(0,0,0,0,0, 1,0,0,0, 0,4);
    // stop on the expiry edge with a start: no rdy, no miss, no err
    addv(0,1,2,0,0, 0,1,0,0, 2,2);
    addv(0,0,0,0,0, 0,1,0,0, 1,2);
    addv(0,1,5,0,1, 0,0,0,0, 0,2);
    // periodic N=1: rdy continuously high
    addv(0,1,1,1,0, 0,1,0,0, 1,1);
    addv(0,0,0,0,0, 1,1,0,0, 1,1);
    addv(0,0,0,0,0, 1,1,0,0, 1,1);
    addv(0,0,0,0,0, 1,1,0,0, 1,1);
    addv(0,0,0,0,1, 0,0,0,0, 0,1);
    // reset mid-count overrides a concurrent start
    addv(0,1,6,0,0, 0,1,0,0, 6,6);
    addv(0,0,0,0,0, 0,1,0,0, 5,6);
    addv(1,1,3,0,0, 0,0,0,0, 0,10);
    for (int i = 0; i < 6; i++)
      addv(0,0,0,0,0, 0,0,0,0, 0,10);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle();
    rst = 1'b1;
    step();
    step();

    build_table();
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].start, vq[i].cnt, vq[i].periodic, vq[i].stop);
      step();
      chk($sformatf("v%0d.rdy", i),  32'(if_a.rdy),       32'(vq[i].e_rdy));
      chk($sformatf("v%0d.busy", i), 32'(if_a.busy),      32'(vq[i].e_busy));
      chk($sformatf("v%0d.miss", i), 32'(if_a.miss),      32'(vq[i].e_miss));
      chk($sformatf("v%0d.err", i),  32'(if_a.err),       32'(vq[i].e_err));
      chk($sformatf("v%0d.rem", i),  32'(if_a.remaining), 32'(vq[i].e_rem));
      chk($sformatf("v%0d.per", i),  32'(if_a.period_o),  32'(vq[i].e_per));
    end

    // Start 8, then start 2 on the 3rd edge after: plain instance rejects it
    // (miss, rdy at +8); retriggerable instance reloads (rdy at +5).
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 16'd8, 1'b0, 1'b0);
    step();
    idle();
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) drive(1'b0, 1'b1, 16'd2, 1'b0, 1'b0);
      else idle();
      step();
      chk($sformatf("retrig0.rdy@%0d", i),  32'(if_a.rdy),  32'(i == 8));
      chk($sformatf("retrig0.miss@%0d", i), 32'(if_a.miss), 32'(i == 3));
      chk($sformatf("retrig0.busy@%0d", i), 32'(if_a.busy), 32'(i < 8));
      chk($sformatf("retrig1.rdy@%0d", i),  32'(if_b.rdy),  32'(i == 5));
      chk($sformatf("retrig1.miss@%0d", i), 32'(if_b.miss), 32'd0);
      chk($sformatf("retrig1.busy@%0d", i), 32'(if_b.busy), 32'(i < 5));
    end
    chk("retrig1.per", 32'(if_b.period_o), 32'd2);

    // One-shot 4 with start(2) on the expiry edge: back-to-back, no miss.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 16'd4, 1'b0, 1'b0);
    step();
    for (int i = 1; i <= 7; i++) begin
      if (i == 4) drive(1'b0, 1'b1, 16'd2, 1'b0, 1'b0);
      else idle();
      step();
      chk($sformatf("b2b.rdy@%0d", i),  32'(if_a.rdy),  32'((i == 4) || (i == 6)));
      chk($sformatf("b2b.busy@%0d", i), 32'(if_a.busy), 32'(i < 6));
      chk($sformatf("b2b.miss@%0d", i), 32'(if_a.miss), 32'd0);
      chk($sformatf("b2b.rem@%0d", i),  32'(if_a.remaining),
          (i < 4) ? 32'(4 - i) : (i == 4) ? 32'd2 : (i == 5) ? 32'd1 : 32'd0);
    end

    // Prescale 4, count 3: rdy 12 clocks after start, counter steps every 4.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 16'd3, 1'b0, 1'b0);
    step();
    chk("ps.rem@0", 32'(if_c.remaining), 32'd3);
    chk("ps.busy@0", 32'(if_c.busy), 32'd1);
    idle();
    for (int i = 1; i <= 14; i++) begin
      step();
      chk($sformatf("ps.rdy@%0d", i),  32'(if_c.rdy),  32'(i == 12));
      chk($sformatf("ps.busy@%0d", i), 32'(if_c.busy), 32'(i < 12));
      chk($sformatf("ps.rem@%0d", i),  32'(if_c.remaining),
          (i < 12) ? 32'(3 - i / 4) : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
